// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
//   Shared encodings for the multiply/divide sequencer: mdOp codes, the Alu
//   function codes it drives, the FSM state type and small op decoders.
package muldiv_sequencer_pkg;

   localparam int MD_WIDTH = 32;

   // mdOp encodings
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // Alu function codes
   localparam logic [5:0] FUN_NO   = 6'h00;
   localparam logic [5:0] FUN_ADDU = 6'h21;
   localparam logic [5:0] FUN_SUBU = 6'h23;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PREP_A = 3'd1,
      ST_PREP_B = 3'd2,
      ST_ITER   = 3'd3,
      ST_FIX_LO = 3'd4,
      ST_FIX_HI = 3'd5,
      ST_DONE   = 3'd6
   } md_state_t;

   // bit 1 selects divide, bit 0 selects unsigned
   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic md_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU engine that borrows the shared 32-bit Alu
//   for every add/subtract. Shift-add multiply and restoring divide on operand
//   magnitudes, followed by a two-step sign fixup. Fixed latency: an accept on
//   edge 0 gives done in cycle 37 for every op.
// Ports
//   clk, reset          clock (rising), asynchronous active-high reset
//   start, mdOp         request and op; sampled only while idle
//   srcA, srcB          rs (multiplicand/dividend), rt (multiplier/divisor)
//   aluOpA/aluOpB       Alu operand drive (combinational from state)
//   aluFunct            Alu function; FUN_NO when idle
//   aluOut              Alu result, same cycle
//   busy, done          busy while not idle; done one-cycle pulse
//   hi, lo              result registers, held between operations
//   divByZero           flags a zero divisor alongside done
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mdOp,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic [WIDTH-1:0] aluOpA,
   output logic [WIDTH-1:0] aluOpB,
   output logic [5:0]       aluFunct,
   input  logic [WIDTH-1:0] aluOut,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divByZero
);

   localparam int CW = $clog2(ITERS);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

   md_state_t        state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_raw;   // original dividend, returned as hi on divide-by-zero
   logic [WIDTH-1:0] acc;     // product high word / remainder
   logic [WIDTH-1:0] lo_w;    // multiplier+product low word / quotient
   logic [WIDTH-1:0] mc;      // multiplicand / divisor
   logic             sign_a;
   logic             sign_b;
   logic             b_zero;
   logic [CW-1:0]    cnt;

   logic             div_op;
   logic             div0;
   logic             neg_lo;
   logic             neg_hi;
   logic [WIDTH-1:0] rem_sh;
   logic             carry;
   logic             dv_take;

   assign div_op = md_is_div(op_q);
   assign div0   = div_op & b_zero;
   // Zero divisor returns the forced result with no sign fixup at all.
   assign neg_lo = ~div0 & (sign_a ^ sign_b);
   assign neg_hi = ~div0 & (div_op ? sign_a : (sign_a ^ sign_b));

   // Remainder after shifting in the next dividend bit; acc[MSB] is the
   // shifted-out bit that forces the trial subtract to be taken.
   assign rem_sh  = {acc[WIDTH-2:0], lo_w[WIDTH-1]};
   assign dv_take = acc[WIDTH-1] | (rem_sh >= mc);
   assign carry   = (aluOut < acc);

   always_comb begin
      aluFunct = FUN_NO;
      aluOpA   = '0;
      aluOpB   = '0;
      case (state)
         ST_PREP_A: begin
            if (sign_a) begin
               aluFunct = FUN_SUBU;
               aluOpB   = lo_w;
            end else begin
               aluFunct = FUN_ADDU;
               aluOpA   = lo_w;
            end
         end
         ST_PREP_B: begin
            if (sign_b) begin
               aluFunct = FUN_SUBU;
               aluOpB   = mc;
            end else begin
               aluFunct = FUN_ADDU;
               aluOpA   = mc;
            end
         end
         ST_ITER: begin
            if (div_op) begin
               aluFunct = FUN_SUBU;
               aluOpA   = rem_sh;
               aluOpB   = mc;
            end else begin
               aluFunct = FUN_ADDU;
               aluOpA   = acc;
               aluOpB   = lo_w[0] ? mc : '0;
            end
         end
         ST_FIX_LO: begin
            if (neg_lo) begin
               aluFunct = FUN_SUBU;
               aluOpB   = lo_w;
            end else begin
               aluFunct = FUN_ADDU;
               aluOpA   = lo_w;
            end
         end
         ST_FIX_HI: begin
            if (neg_hi) begin
               aluFunct = FUN_SUBU;
               aluOpB   = acc;
               // 64-bit negate of the product: the high word only takes the
               // +1 when the low word was zero. lo_w already holds the negated
               // low word, which is zero exactly when the original was.
               if (!div_op && lo_w != '0)
                  aluOpA = '1;
            end else begin
               aluFunct = FUN_ADDU;
               aluOpA   = acc;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         a_raw     <= '0;
         acc       <= '0;
         lo_w      <= '0;
         mc        <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         b_zero    <= 1'b0;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         divByZero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q      <= mdOp;
                  a_raw     <= srcA;
                  lo_w      <= srcA;
                  mc        <= srcB;
                  sign_a    <= md_is_signed(mdOp) & srcA[WIDTH-1];
                  sign_b    <= md_is_signed(mdOp) & srcB[WIDTH-1];
                  b_zero    <= (srcB == '0);
                  acc       <= '0;
                  cnt       <= '0;
                  divByZero <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_PREP_A;
               end
            end
            ST_PREP_A: begin
               lo_w  <= aluOut;
               state <= ST_PREP_B;
            end
            ST_PREP_B: begin
               mc    <= aluOut;
               state <= ST_ITER;
            end
            ST_ITER: begin
               if (div_op) begin
                  if (dv_take) begin
                     acc  <= aluOut;
                     lo_w <= {lo_w[WIDTH-2:0], 1'b1};
                  end else begin
                     acc  <= rem_sh;
                     lo_w <= {lo_w[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc  <= {carry, aluOut[WIDTH-1:1]};
                  lo_w <= {aluOut[0], lo_w[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST)
                  state <= ST_FIX_LO;
            end
            ST_FIX_LO: begin
               lo_w  <= aluOut;
               state <= ST_FIX_HI;
            end
            ST_FIX_HI: begin
               if (div0) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= aluOut;
                  lo <= lo_w;
               end
               divByZero <= div0;
               done      <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench: models the parent's Alu, drives directed and random
//   ops, and compares hi/lo/divByZero and timing against plain 64-bit
//   arithmetic.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mdOp;
   logic [31:0] srcA, srcB;
   logic [31:0] aluOpA, aluOpB, aluOut;
   logic [5:0]  aluFunct;
   logic        busy, done, divByZero;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
      .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
      .srcA(srcA), .srcB(srcB), .aluOpA(aluOpA), .aluOpB(aluOpB),
      .aluFunct(aluFunct), .aluOut(aluOut), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .divByZero(divByZero)
   );

   always #5 clk = ~clk;

   // Parent's Alu
   always_comb begin
      case (aluFunct)
         FUN_ADDU: aluOut = aluOpA + aluOpB;
         FUN_SUBU: aluOut = aluOpA - aluOpB;
         default:  aluOut = 32'h0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {hi,lo} from ordinary 64-bit arithmetic (truncating division).
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, output logic dbz);
      longint sa, sb, q, r, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dbz = 1'b0;
      case (op)
         MD_MULT:  begin p = sa * sb; return p; end
         MD_MULTU: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); return p; end
         default: begin
            if (b == 32'h0) begin
               dbz = 1'b1;
               return {a, 32'hFFFFFFFF};
            end
            if (op == MD_DIV) begin
               q = sa / sb;
               r = sa % sb;
            end else begin
               q = longint'({32'h0, a}) / longint'({32'h0, b});
               r = longint'({32'h0, a}) % longint'({32'h0, b});
            end
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // One op with start pulsed for the accept cycle; inputs are scrambled
   // right after the accept edge.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      logic        edbz;
      int          done_cyc, done_cnt, busy_cnt;
      e = model(op, a, b, edbz);
      @(negedge clk);
      start = 1'b1; mdOp = op; srcA = a; srcB = b;
      @(posedge clk);
      #1;
      start = 1'b0; mdOp = 2'($urandom); srcA = $urandom; srcB = $urandom;
      done_cyc = -1; done_cnt = 0; busy_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 39) begin
            chk({tag, " idle_funct"}, aluFunct, FUN_NO);
            chk({tag, " idle_ops"}, {aluOpA, aluOpB}, 64'h0);
         end
      end
      chk({tag, " done_cycle"}, done_cyc, 37);
      chk({tag, " done_pulses"}, done_cnt, 1);
      chk({tag, " busy_cycles"}, busy_cnt, 37);
      chk({tag, " hi"}, hi, e[63:32]);
      chk({tag, " lo"}, lo, e[31:0]);
      chk({tag, " dbz"}, divByZero, edbz);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] e1, e2;
      logic        d1, d2;
      logic [31:0] a, b, a2, b2;
      logic [1:0]  op;
      int          dc[$];

      reset = 1'b1; start = 1'b0; mdOp = 2'b00; srcA = 32'h0; srcB = 32'h0;
      #2;
      chk("reset hi_lo", {hi, lo}, 64'h0);
      chk("reset flags", {busy, done, divByZero}, 3'b000);
      chk("reset funct", aluFunct, FUN_NO);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd7);
      run_op("mult_min", MD_MULT, 32'h80000000, 32'h80000000);
      run_op("div_neg_a", MD_DIV, 32'hFFFFFFF9, 32'd2);
      run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2);
      run_op("div_neg_b", MD_DIV, 32'd7, 32'hFFFFFFFE);
      run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_op("divu_zero", MD_DIVU, 32'd5, 32'd0);

      // Reset in the middle of an op, with nonzero results and divByZero set.
      @(negedge clk);
      start = 1'b1; mdOp = MD_MULT; srcA = 32'h12345678; srcB = 32'h9ABCDEF0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset hi_lo", {hi, lo}, 64'h0);
      chk("midreset flags", {busy, done, divByZero}, 3'b000);
      chk("midreset funct", aluFunct, FUN_NO);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_reset", MD_MULTU, 32'd6, 32'd7);

      // start held high: back-to-back accepts, operands changed after accept.
      a2 = 32'hFFFF0001; b2 = 32'h00000123;
      e1 = model(MD_MULTU, 32'd1000, 32'd3000, d1);
      e2 = model(MD_DIV, a2, b2, d2);
      @(negedge clk);
      start = 1'b1; mdOp = MD_MULTU; srcA = 32'd1000; srcB = 32'd3000;
      @(posedge clk);
      #1;
      mdOp = MD_DIV; srcA = a2; srcB = b2;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (c == 40) start = 1'b0;
         if (done) begin
            dc.push_back(c);
            if (dc.size() == 1) chk("held first", {hi, lo}, e1);
            if (dc.size() == 2) chk("held second", {hi, lo}, e2);
         end
      end
      chk("held pulses", dc.size(), 2);
      if (dc.size() == 2) begin
         chk("held cyc1", dc[0], 37);
         chk("held cyc2", dc[1], 75);
      end
      chk("held idle", busy, 1'b0);

      // Random ops
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom);
         a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'h0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFFFFFF;
            3:       b = 32'h80000000;
            default: b = $urandom;
         endcase
         run_op($sformatf("rnd%0d", i), op, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
